rgb_serializer: RTL
===================

# rgb_serializer

- Reads packed 24-bit RGB pixels from the frame buffer in raster order.
- Emits them as a byte stream, one color per cycle in R, G, B order, with valid and row-end flags.
- It is the transmitting end of the blur filter's pixel-input interface and sits between frame-buffer read logic and the blur stage.
- Memory reads are pipelined through a 2-entry prefetch FIFO so the stream can sustain one byte per cycle.

## Interface
Parameters:
- IMG_WIDTH, 640: pixels per row (≥2)
- IMG_HEIGHT, 480: rows per frame (≥1)
- ADDR_W, 19: read-address width; must hold IMG_WIDTH*IMG_HEIGHT-1
- ROW_GAP, 4: idle cycles inserted after each row (only with SER_ROW_GAP_EN)

Ports (one clock; reset is asynchronous and active-low):
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle pulse, starts a frame; ignored while o_busy
- i_hold  in  1  downstream pause; freezes the stream
- o_busy  out  1  high from the cycle after accepted i_start until o_done
- o_done  out  1  one-cycle pulse, frame fully emitted
- o_rd_req  out  1  read request, one pixel per asserted cycle
- o_rd_addr  out  ADDR_W  pixel address, valid with o_rd_req
- i_rd_valid  in  1  read data valid; in order, latency ≥1, fixed or variable
- i_rd_data  in  24  {R[23:16], G[15:8], B[7:0]}
- o_valid  out  1  o_pixel valid
- o_pixel  out  8  R, G or B byte
- o_row_end  out  1  high with the B byte of the last pixel of each row

## Operation
- States:
  - IDLE: wait for i_start.
  - RUN: issue reads and emit bytes.
  - GAP: row gap; exists only with the macro.
  - IDLE again after the final byte.
- IDLE→RUN on i_start. On entry, clear the address, column, row and color counters.
- Read issue: assert o_rd_req in RUN when addresses remain and (fifo_count + outstanding) < 2.
  - o_rd_addr increments 0 … W*H-1 per request.
  - The outstanding counter is 2 bits: +1 on request, −1 on i_rd_valid.
- i_rd_valid pushes i_rd_data into the FIFO.
  - In IDLE it is discarded and the outstanding count is not changed.
  - i_rd_valid while the FIFO is full cannot occur by credit; the bench checks this with an assertion.
- Emit: when the FIFO is non-empty, !i_hold and state is RUN:
  - Output the byte selected by the color counter (RED→GREEN→BLUE→RED).
  - Pop the FIFO on BLUE.
  - Column counter increments on BLUE and wraps at IMG_WIDTH-1.
  - Row counter increments on each column wrap.
- o_row_end = (color==BLUE) && (col==IMG_WIDTH-1).
- Frame end: the BLUE byte of pixel W*H-1 raises the done flag.
  - o_done pulses in the same cycle that byte appears on o_pixel.
  - The FSM returns to IDLE. o_busy falls with o_done.
- i_hold may assert mid-pixel. The color counter freezes, and emission resumes at the held color with no byte lost or repeated. Reads continue until credit is exhausted.
- A FIFO empty mid-row creates a bubble (o_valid low). This is legal, and the downstream treats it like hold.

## Timing
- Reset values: o_busy=0, o_done=0, o_rd_req=0, o_rd_addr=0, o_valid=0, o_pixel=0, o_row_end=0. FSM=IDLE; all counters and the FIFO are cleared.
- All outputs are registered.
- o_rd_req is first asserted 1 cycle after i_start.
- First o_valid appears 2 cycles after the first i_rd_valid: capture into the FIFO, then the output register.
- Throughput: 1 byte/cycle when read latency ≤2. One read per 3 cycles is enough to sustain it.
- i_hold rising in cycle t: o_valid is low from t+1. Falling in t: o_valid resumes at t+1.
- Reset mid-frame: immediate return to reset values. Late i_rd_valid returns are dropped in IDLE.
- i_start in the same cycle as o_done: ignored, because o_busy is still high.

## Configuration
- SER_ROW_GAP_EN defined:
  - After each o_row_end, except the last row's, enter GAP for ROW_GAP cycles with o_valid=0.
  - Reads continue filling the FIFO during GAP.
  - Then return to RUN.
- Undefined: GAP does not exist; rows are back-to-back and ROW_GAP is unused.

## Structure
- Package blur_pkg:
  - color_t enum {RED=0, GREEN=1, BLUE=2} (2 bits)
  - rgb_t packed struct {r, g, b} of 8 bits each
  - ser_state_t {IDLE, RUN, GAP}
- Shared with the blur filter's color sequencing.
- One sub-module: pix_fifo2, a 2-entry rgb_t FIFO with push/pop/count[1:0]/full/empty.

## Test plan
- W=2, H=1, 1-cycle memory returning 0x112233, 0x445566 → bytes 11,22,33,44,55,66 on consecutive cycles. o_row_end only with 66; o_done with 66.
- W=4, H=2, latency 3 → 24 bytes in raster order. o_row_end on bytes 12 and 24; o_rd_addr 0..7 each exactly once; outstanding never exceeds 2.
- i_hold high for 5 cycles starting after G of pixel 1 (0xA0B0C0) → o_valid low 5 cycles, then C0 next. No byte dropped or repeated.
- Reset asserted mid-frame, then i_rd_valid pulses in IDLE, then i_start → outputs at reset values during reset. New frame starts at o_rd_addr 0 with the first byte R of pixel 0.
- SER_ROW_GAP_EN, ROW_GAP=4, W=2, H=2 → exactly 4 o_valid=0 cycles between o_row_end and the first R of row 1. No gap after the final row.
- i_start pulsed while o_busy → ignored; exactly one o_done per frame.

Source files
------------

// File: rtl/blur_pkg.sv
// Shared types for the blur pipeline: color sequencing, packed RGB pixel, serializer states.
// Also holds the byte-select helpers used by the serializer and the blur filter.
package blur_pkg;

  typedef enum logic [1:0] {
    RED   = 2'd0,
    GREEN = 2'd1,
    BLUE  = 2'd2
  } color_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } ser_state_t;

  function automatic color_t next_color(input color_t c);
    case (c)
      RED:     next_color = GREEN;
      GREEN:   next_color = BLUE;
      default: next_color = RED;
    endcase
  endfunction

  function automatic logic [7:0] color_byte(input rgb_t px, input color_t c);
    case (c)
      RED:     color_byte = px.r;
      GREEN:   color_byte = px.g;
      default: color_byte = px.b;
    endcase
  endfunction

endpackage

// File: rtl/pix_fifo2.sv
// Two-entry first-word-fall-through pixel FIFO; rd_data shows the head entry whenever !empty.
module pix_fifo2
  import blur_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  rgb_t       wr_data,
  output rgb_t       rd_data,
  output logic [1:0] count,
  output logic       full,
  output logic       empty
);

  rgb_t mem [2];
  logic wr_ptr;
  logic rd_ptr;
  logic do_push;
  logic do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/rgb_serializer.sv
// Frame-buffer reader that streams raster-order pixels as R,G,B bytes with row-end and done flags.
// Define SER_ROW_GAP_EN to insert ROW_GAP idle cycles after every row except the last.
module rgb_serializer
  import blur_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int ADDR_W     = 19,
  parameter int ROW_GAP    = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_req,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic              i_rd_valid,
  input  logic [23:0]       i_rd_data,
  output logic              o_valid,
  output logic [7:0]        o_pixel,
  output logic              o_row_end
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_WIDTH * IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(IMG_HEIGHT - 1);

  if (IMG_WIDTH < 2 || IMG_HEIGHT < 1 || ROW_GAP < 0 ||
      longint'(IMG_WIDTH) * longint'(IMG_HEIGHT) > (longint'(1) << ADDR_W)) begin : g_bad_cfg
    $error("rgb_serializer: illegal parameter set");
  end

  ser_state_t        state;
  color_t            color;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] addr_next;
  logic              addr_left;
  logic [1:0]        outstanding;
`ifdef SER_ROW_GAP_EN
  localparam int GAP_W = (ROW_GAP > 1) ? $clog2(ROW_GAP) : 1;
  logic [GAP_W-1:0]  gap_cnt;
`endif

  rgb_t       fifo_rd;
  logic [1:0] fifo_count;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic       vld_p0;
  logic       row_last;
  logic       frame_last;
  logic [2:0] in_use;
  logic       req_ok;

  // Emit decision for the byte registered this edge; pop retires the pixel on its blue byte.
  assign vld_p0     = (state == RUN) && !fifo_empty && !i_hold;
  assign row_last   = (col == LAST_COL);
  assign frame_last = row_last && (row == LAST_ROW);
  assign pop        = vld_p0 && (color == BLUE);
  assign push       = i_rd_valid && (state != IDLE) && (!fifo_full || pop);

  // Credit counts the slot freed by this edge's pop so latency-2 memory keeps up.
  assign in_use = {1'b0, fifo_count} + {1'b0, outstanding} - {2'b00, pop};
  assign req_ok = (state != IDLE) && addr_left && (in_use < 3'd2);

  pix_fifo2 u_fifo (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data (rgb_t'(i_rd_data)),
    .rd_data (fifo_rd),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      color       <= RED;
      col         <= '0;
      row         <= '0;
      addr_next   <= '0;
      addr_left   <= 1'b0;
      outstanding <= 2'd0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_rd_req    <= 1'b0;
      o_rd_addr   <= '0;
      o_valid     <= 1'b0;
      o_pixel     <= '0;
      o_row_end   <= 1'b0;
`ifdef SER_ROW_GAP_EN
      gap_cnt     <= '0;
`endif
    end else begin
      o_rd_req  <= 1'b0;
      o_valid   <= vld_p0;
      o_row_end <= vld_p0 && (color == BLUE) && row_last;
      o_done    <= vld_p0 && (color == BLUE) && frame_last;
      if (vld_p0) o_pixel <= color_byte(fifo_rd, color);
      if (o_done) o_busy <= 1'b0;

      case (state)
        IDLE: begin
          // o_busy stays high through the done cycle, which blocks a start landing on it.
          if (i_start && !o_busy) begin
            state       <= RUN;
            o_busy      <= 1'b1;
            color       <= RED;
            col         <= '0;
            row         <= '0;
            o_rd_req    <= 1'b1;
            o_rd_addr   <= '0;
            addr_next   <= ADDR_W'(1);
            addr_left   <= 1'b1;
            outstanding <= 2'd1;
          end
        end
        default: begin
          if (req_ok) begin
            o_rd_req  <= 1'b1;
            o_rd_addr <= addr_next;
            addr_next <= addr_next + 1'b1;
            if (addr_next == LAST_ADDR) addr_left <= 1'b0;
          end
          outstanding <= outstanding + {1'b0, req_ok} - {1'b0, i_rd_valid};
          if (vld_p0) begin
            color <= next_color(color);
            if (color == BLUE) begin
              if (row_last) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
              if (frame_last) begin
                state <= IDLE;
              end
`ifdef SER_ROW_GAP_EN
              else if (row_last && ROW_GAP > 0) begin
                state   <= GAP;
                gap_cnt <= GAP_W'(ROW_GAP - 1);
              end
`endif
            end
          end
`ifdef SER_ROW_GAP_EN
          if (state == GAP) begin
            if (gap_cnt == '0) state <= RUN;
            else               gap_cnt <= gap_cnt - 1'b1;
          end
`endif
        end
      endcase
    end
  end

endmodule
